// File: rtl/line_buffer_if.sv
// line_buffer_if: pixel write/read handshake plus status/error bundle for line_buffer.
interface line_buffer_if #(
  parameter int DW = 4,
  parameter int AW = 10
);
  logic          mode, wr_en, rd_en, clr_err;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_valid, empty, full, ovf, udf;
  logic [AW-1:0] usage;
  modport master (
    output mode, wr_en, wr_data, rd_en, clr_err,
    input  rd_data, rd_valid, empty, full, usage, ovf, udf
  );
  modport slave (
    input  mode, wr_en, wr_data, rd_en, clr_err,
    output rd_data, rd_valid, empty, full, usage, ovf, udf
  );
endinterface

// File: rtl/line_buffer.sv
// line_buffer: DEPTH-pixel line store, LIFO (line reversal) or FIFO (pass-through) order.
module line_buffer #(
  parameter int DW    = 4,
  parameter int DEPTH = 800,
  parameter int AW    = 10
) (
  input logic          clk,
  input logic          rst,
  line_buffer_if.slave bus
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] count_q, count_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr, rd_addr;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          mode_q, mode_d, rd_valid_q, rd_valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic          empty, full, wr_acc, rd_acc;
  always_comb begin
    empty      = count_q == '0;
    full       = count_q == AW'(DEPTH);
    wr_acc     = bus.wr_en && !full;
    rd_acc     = bus.rd_en && !empty;
    rd_addr    = mode_q ? rd_ptr_q : count_q - 1'b1;
    // a LIFO read+write pops the top and pushes into the same slot
    wr_addr    = mode_q ? wr_ptr_q : (rd_acc ? count_q - 1'b1 : count_q);
    count_d    = count_q + AW'(wr_acc) - AW'(rd_acc);
    wr_ptr_d   = (mode_q && wr_acc) ? (wr_ptr_q == AW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d   = (mode_q && rd_acc) ? (rd_ptr_q == AW'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    mode_d     = (empty && !bus.wr_en) ? bus.mode : mode_q;
    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? mem[rd_addr] : rd_data_q;
    ovf_d      = (ovf_q && !bus.clr_err) || (bus.wr_en && full);
    udf_d      = (udf_q && !bus.clr_err) || (bus.rd_en && empty);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mode_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mode_q     <= mode_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end
  always_ff @(posedge clk)
    if (rst && wr_acc) mem[wr_addr] <= bus.wr_data;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.usage    = count_q;
  assign bus.ovf      = ovf_q;
  assign bus.udf      = udf_q;
endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: directed and random scenarios checked against a queue-based line model.
module tb_line_buffer;
  localparam int DW = 4, DEPTH = 800, AW = 10;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  line_buffer_if #(.DW(DW), .AW(AW)) bi ();
  line_buffer #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bi));
  int tests = 0, fails = 0;
  int q[$];
  bit m_mode, m_ovf, m_udf, m_valid;
  int m_data;

  task automatic step(input bit md, input bit we, input int wd, input bit re, input bit ce);
    bit e, f;
    @(negedge clk);
    rst = 1'b1; bi.mode = md; bi.wr_en = we; bi.wr_data = DW'(wd); bi.rd_en = re; bi.clr_err = ce;
    @(posedge clk);
    e = q.size() == 0;
    f = q.size() == DEPTH;
    m_valid = re && !e;
    if (m_valid) m_data = m_mode ? q.pop_front() : q.pop_back();
    if (we && !f) q.push_back(wd & ((1 << DW) - 1));
    if (e && !we) m_mode = md;
    m_ovf = (m_ovf && !ce) || (we && f);
    m_udf = (m_udf && !ce) || (re && e);
    #1;
  endtask

  task automatic do_reset(input bit re);
    @(negedge clk);
    rst = 1'b0; bi.mode = 1'b1; bi.wr_en = 1'b1; bi.wr_data = '1; bi.rd_en = re; bi.clr_err = 1'b0;
    @(posedge clk);
    q.delete();
    m_mode = 0; m_ovf = 0; m_udf = 0; m_valid = 0; m_data = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset(0);
    tests++; if (bi.empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", bi.empty); end
    tests++; if (bi.full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", bi.full); end
    tests++; if (bi.usage !== '0) begin fails++; $display("FAIL reset_usage got %0d exp 0", bi.usage); end
    tests++; if (bi.rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid got %b exp 0", bi.rd_valid); end
    tests++; if (bi.rd_data !== '0) begin fails++; $display("FAIL reset_rd_data got %0d exp 0", bi.rd_data); end
    tests++; if ({bi.ovf, bi.udf} !== 2'b00) begin fails++; $display("FAIL reset_err got %b%b exp 00", bi.ovf, bi.udf); end
  endtask

  task automatic test_lifo();
    do_reset(0);
    for (int i = 1; i <= 3; i++) step(0, 1, i, 0, 0);
    for (int i = 3; i >= 1; i--) begin
      step(0, 0, 0, 1, 0);
      tests++; if (bi.rd_valid !== 1'b1 || bi.rd_data !== DW'(i)) begin fails++; $display("FAIL lifo_read got v=%b d=%0d exp v=1 d=%0d", bi.rd_valid, bi.rd_data, i); end
    end
    step(0, 0, 0, 0, 0);
    tests++; if (bi.rd_valid !== 1'b0 || bi.rd_data !== DW'(1)) begin fails++; $display("FAIL lifo_hold got v=%b d=%0d exp v=0 d=1", bi.rd_valid, bi.rd_data); end
    tests++; if (bi.empty !== 1'b1) begin fails++; $display("FAIL lifo_empty got %b exp 1", bi.empty); end
  endtask

  task automatic test_fifo();
    int n;
    do_reset(0);
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) step(1, 1, i, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 1, 0);
      tests++; if (bi.rd_valid !== 1'b1 || bi.rd_data !== DW'(i)) begin fails++; $display("FAIL fifo_read got v=%b d=%0d exp v=1 d=%0d", bi.rd_valid, bi.rd_data, i); end
    end
    run_random(2 * DEPTH + 400, 1, 1);
    n = 0;
    while (q.size() != 0 && n < DEPTH + 1) begin
      step(1, 0, 0, 1, 0); n++;
      tests++; if (bi.rd_valid !== 1'b1 || bi.rd_data !== DW'(m_data)) begin fails++; $display("FAIL fifo_drain got v=%b d=%0d exp v=1 d=%0d", bi.rd_valid, bi.rd_data, m_data); end
    end
    tests++; if (bi.usage !== '0 || bi.empty !== 1'b1) begin fails++; $display("FAIL fifo_usage_end got %0d exp 0", bi.usage); end
  endtask

  task automatic run_random(input int n, input bit fixed, input bit md_val);
    bit md = md_val;
    for (int i = 0; i < n; i++) begin
      if (!fixed && $urandom_range(0, 7) == 0) md = ~md;
      step(md, $urandom_range(0, 9) < 6, int'($urandom), $urandom_range(0, 9) < 5, $urandom_range(0, 15) == 0);
      tests++; if (bi.rd_valid !== m_valid) begin fails++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, bi.rd_valid, m_valid); end
      tests++; if (bi.rd_data !== DW'(m_data)) begin fails++; $display("FAIL rnd_data cyc %0d got %0d exp %0d", i, bi.rd_data, m_data); end
      tests++; if (bi.usage !== AW'(q.size()) || bi.empty !== (q.size() == 0) || bi.full !== (q.size() == DEPTH)) begin fails++; $display("FAIL rnd_count cyc %0d got %0d e%b f%b exp %0d", i, bi.usage, bi.empty, bi.full, q.size()); end
      tests++; if (bi.ovf !== m_ovf || bi.udf !== m_udf) begin fails++; $display("FAIL rnd_err cyc %0d got %b%b exp %b%b", i, bi.ovf, bi.udf, m_ovf, m_udf); end
    end
  endtask

  task automatic test_full();
    do_reset(0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, int'($urandom), 0, 0);
    tests++; if (bi.full !== 1'b1 || bi.usage !== AW'(DEPTH)) begin fails++; $display("FAIL full_flag got f=%b u=%0d exp f=1 u=%0d", bi.full, bi.usage, DEPTH); end
    step(0, 1, 5, 0, 0);
    tests++; if (bi.ovf !== 1'b1 || bi.usage !== AW'(DEPTH)) begin fails++; $display("FAIL full_ovf got o=%b u=%0d exp o=1 u=%0d", bi.ovf, bi.usage, DEPTH); end
    step(0, 0, 0, 0, 1);
    tests++; if (bi.ovf !== 1'b0) begin fails++; $display("FAIL full_clr got %b exp 0", bi.ovf); end
    step(0, 1, 3, 1, 0);
    tests++; if (bi.rd_valid !== 1'b1 || bi.rd_data !== DW'(m_data) || bi.usage !== AW'(DEPTH - 1) || bi.ovf !== 1'b1) begin fails++; $display("FAIL full_rdwr got v=%b d=%0d u=%0d o=%b exp v=1 d=%0d u=%0d o=1", bi.rd_valid, bi.rd_data, bi.usage, bi.ovf, m_data, DEPTH - 1); end
  endtask

  task automatic test_underflow();
    do_reset(0);
    step(0, 0, 0, 1, 0);
    tests++; if (bi.rd_valid !== 1'b0 || bi.udf !== 1'b1) begin fails++; $display("FAIL udf_set got v=%b u=%b exp v=0 u=1", bi.rd_valid, bi.udf); end
    step(0, 1, 5, 1, 0);
    tests++; if (bi.rd_valid !== 1'b0 || bi.usage !== AW'(1)) begin fails++; $display("FAIL udf_rdwr got v=%b u=%0d exp v=0 u=1", bi.rd_valid, bi.usage); end
    step(0, 0, 0, 1, 1);
    tests++; if (bi.rd_data !== DW'(5) || bi.udf !== 1'b0) begin fails++; $display("FAIL udf_clr got d=%0d u=%b exp d=5 u=0", bi.rd_data, bi.udf); end
    step(0, 0, 0, 1, 1);
    tests++; if (bi.udf !== 1'b1) begin fails++; $display("FAIL udf_set_wins got %b exp 1", bi.udf); end
  endtask

  task automatic test_lifo_simul();
    do_reset(0);
    step(0, 1, 5, 0, 0);
    step(0, 1, 6, 0, 0);
    step(0, 1, 9, 1, 0);
    tests++; if (bi.rd_data !== DW'(6) || bi.usage !== AW'(2)) begin fails++; $display("FAIL simul_rdwr got d=%0d u=%0d exp d=6 u=2", bi.rd_data, bi.usage); end
    step(0, 0, 0, 1, 0);
    tests++; if (bi.rd_data !== DW'(9)) begin fails++; $display("FAIL simul_second got %0d exp 9", bi.rd_data); end
    step(0, 0, 0, 1, 0);
    tests++; if (bi.rd_data !== DW'(5)) begin fails++; $display("FAIL simul_third got %0d exp 5", bi.rd_data); end
  endtask

  task automatic test_mode_toggle();
    do_reset(0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 2, 0, 0);
    step(1, 0, 0, 1, 0);
    tests++; if (bi.rd_data !== DW'(2)) begin fails++; $display("FAIL toggle_order got %0d exp 2", bi.rd_data); end
    step(1, 1, 4, 0, 0);
    do_reset(1);
    tests++; if (bi.rd_valid !== 1'b0 || bi.usage !== '0) begin fails++; $display("FAIL rst_midread got v=%b u=%0d exp v=0 u=0", bi.rd_valid, bi.usage); end
    step(1, 1, 7, 0, 0);
    step(1, 1, 8, 0, 0);
    step(1, 0, 0, 1, 0);
    tests++; if (bi.rd_data !== DW'(8)) begin fails++; $display("FAIL rst_mode_lifo got %0d exp 8", bi.rd_data); end
  endtask

  initial begin
    bi.mode = 0; bi.wr_en = 0; bi.wr_data = '0; bi.rd_en = 0; bi.clr_err = 0;
    test_reset();
    test_lifo();
    test_fifo();
    test_full();
    test_underflow();
    test_lifo_simul();
    test_mode_toggle();
    do_reset(0);
    run_random(3000, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
